prach_fcw_sched: RTL and testbench

- Frequency-control-word scheduler for the PRACH mixer channel path.
- Holds a shadow bank of 8 per-channel 17-bit FCWs written through a valid/ready config port. Copies the shadow bank into the active bank that drives the mixer/NCO `ctrl_fcw[8]`.
- The copy happens atomically on a `sync_in` (TDM slot-0) boundary, so all channels retune in the same TDM round.
- Sits between the control/register plane and the mixer, sharing that mixer's `sync_in`.

---
 rtl/prach_pkg.sv | 15 +
 rtl/prach_fcw_bank.sv | 74 +++++++
 rtl/prach_fcw_sched.sv | 130 +++++++++++++
 tb/tb_prach_fcw_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// Shared types and sizes for the PRACH frequency-control-word scheduler.
package prach_pkg;

    localparam int PRACH_NUM_CH = 8;
    localparam int PRACH_FCW_W  = 17;

    typedef logic [PRACH_FCW_W-1:0] fcw_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } fcw_sched_state_e;

endpackage

// File: rtl/prach_fcw_bank.sv
// Shadow/active FCW register pair with write port, copy strobe and optional
// readback (PRACH_FCW_READBACK_EN).
module prach_fcw_bank
    import prach_pkg::*;
#(
    parameter int NUM_CH = PRACH_NUM_CH,
    parameter int FCW_W  = PRACH_FCW_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_chn,
    input  logic [FCW_W-1:0]          wr_fcw,
    input  logic                      copy,
`ifdef PRACH_FCW_READBACK_EN
    input  logic [$clog2(NUM_CH)-1:0] rd_chn,
    output logic [FCW_W-1:0]          rd_fcw,
`endif
    output logic [FCW_W-1:0]          active [NUM_CH]
);

    localparam int CHN_W = $clog2(NUM_CH);

    logic [FCW_W-1:0] shadow_r [NUM_CH];
    logic [FCW_W-1:0] active_r [NUM_CH];

    // Shadow bank: per-slot decode, so indices without a slot are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) shadow_r[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && (wr_chn == CHN_W'(k))) shadow_r[k] <= wr_fcw;
            end
        end
    end

    // Active bank: whole-bank copy on the strobe, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) active_r[k] <= '0;
        end else if (copy) begin
            for (int k = 0; k < NUM_CH; k++) active_r[k] <= shadow_r[k];
        end
    end

    assign active = active_r;

`ifdef PRACH_FCW_READBACK_EN
    logic [FCW_W-1:0] rd_mux_s;
    logic [FCW_W-1:0] rd_fcw_r;

    // Readback select; an index with no slot yields zero.
    always_comb begin
        rd_mux_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_chn == CHN_W'(k)) begin
                rd_mux_s = active_r[k];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Readback output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_fcw_r <= '0;
        else        rd_fcw_r <= rd_mux_s;
    end

    assign rd_fcw = rd_fcw_r;
`endif

endmodule

// File: rtl/prach_fcw_sched.sv
// FCW scheduler: shadow writes in IDLE, atomic shadow->active copy on sync_in.
// Optional readback port enabled by PRACH_FCW_READBACK_EN.
module prach_fcw_sched
    import prach_pkg::*;
#(
    parameter int NUM_CH  = PRACH_NUM_CH,
    parameter int FCW_W   = PRACH_FCW_W,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sync_in,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_chn,
    input  logic [FCW_W-1:0]          cfg_fcw,
    input  logic                      commit_req,
    output logic                      commit_busy,
    output logic                      commit_done,
    output logic                      err_timeout,
    input  logic                      err_clr,
`ifdef PRACH_FCW_READBACK_EN
    input  logic [$clog2(NUM_CH)-1:0] rd_chn,
    output logic [FCW_W-1:0]          rd_fcw,
`endif
    output logic [FCW_W-1:0]          ctrl_fcw [NUM_CH]
);

    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    fcw_sched_state_e state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cfg_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             wr_en_s;
    logic             copy_s;
    logic             timeout_hit_s;
    logic             err_set_s;

    assign wr_en_s       = cfg_valid && cfg_ready_r;
    assign copy_s        = (state_r == APPLY);
    assign timeout_hit_s = TO_EN && (cnt_r == TO_LAST);
    // sync_in wins over a coincident timeout, so no error is flagged then.
    assign err_set_s     = (state_r == ARMED) && !sync_in && timeout_hit_s;

    // Commit FSM, timeout counter and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (commit_req) begin
                        state_r     <= ARMED;
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                ARMED: begin
                    if (sync_in || timeout_hit_s) begin
                        state_r <= APPLY;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ARMED;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        done_r  <= 1'b0;
                    end
                end
                APPLY: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    cfg_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    cfg_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         err_r <= 1'b0;
        else if (err_set_s) err_r <= 1'b1;
        else if (err_clr)   err_r <= 1'b0;
    end

    assign cfg_ready   = cfg_ready_r;
    assign commit_busy = busy_r;
    assign commit_done = done_r;
    assign err_timeout = err_r;

    prach_fcw_bank #(
        .NUM_CH (NUM_CH),
        .FCW_W  (FCW_W)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en_s),
        .wr_chn (cfg_chn),
        .wr_fcw (cfg_fcw),
        .copy   (copy_s),
`ifdef PRACH_FCW_READBACK_EN
        .rd_chn (rd_chn),
        .rd_fcw (rd_fcw),
`endif
        .active (ctrl_fcw)
    );

endmodule

// File: tb/tb_prach_fcw_sched.sv
// Scoreboard bench for prach_fcw_sched: expected active banks are queued at
// commit time and compared once the copy has landed.
module tb_prach_fcw_sched;
    import prach_pkg::*;

    localparam int NCH = 8;
    localparam int W   = 17;
    localparam int TO  = 16;

    typedef logic [NCH*W-1:0] bank_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sync_in = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [2:0]   cfg_chn = 3'd0;
    logic [W-1:0] cfg_fcw = '0;
    logic         commit_req = 1'b0;
    logic         commit_busy;
    logic         commit_done;
    logic         err_timeout;
    logic         err_clr = 1'b0;
    logic [W-1:0] ctrl_fcw [NCH];
`ifdef PRACH_FCW_READBACK_EN
    logic [2:0]   rd_chn = 3'd0;
    logic [W-1:0] rd_fcw;
`endif

    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] shadow_m [NCH];
    bank_t        exp_q [$];

    prach_fcw_sched #(.NUM_CH(NCH), .FCW_W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_in     (sync_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chn     (cfg_chn),
        .cfg_fcw     (cfg_fcw),
        .commit_req  (commit_req),
        .commit_busy (commit_busy),
        .commit_done (commit_done),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
`ifdef PRACH_FCW_READBACK_EN
        .rd_chn      (rd_chn),
        .rd_fcw      (rd_fcw),
`endif
        .ctrl_fcw    (ctrl_fcw)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bank_t model_bank();
        bank_t b;
        for (int k = 0; k < NCH; k++) b[k*W +: W] = shadow_m[k];
        return b;
    endfunction

    task automatic check_bank(input string tag, input bank_t exp);
        for (int k = 0; k < NCH; k++)
            check_eq($sformatf("%s[%0d]", tag, k), 32'(ctrl_fcw[k]), 32'(exp[k*W +: W]));
    endtask

    task automatic write_fcw(input int chn, input logic [W-1:0] fcw, input bit accept);
        cfg_valid = 1'b1;
        cfg_chn   = 3'(chn);
        cfg_fcw   = fcw;
        tick();
        cfg_valid = 1'b0;
        if (accept) shadow_m[chn] = fcw;
    endtask

    task automatic commit_arm();
        commit_req = 1'b1;
        exp_q.push_back(model_bank());
        tick();
        commit_req = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (commit_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Called in the commit_done cycle: the new bank is due one edge later.
    task automatic apply_check(input string tag);
        bank_t e;
        tick();
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_bank(tag, e);
        end
    endtask

    initial begin
        int n;
        bit seen;
        for (int k = 0; k < NCH; k++) shadow_m[k] = '0;

        #12;
        check_eq("rst_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_busy", 32'(commit_busy), 32'd0);
        check_eq("rst_done", 32'(commit_done), 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        check_bank("rst_ctrl", '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Shadow writes alone never reach the mixer.
        for (int k = 0; k < NCH; k++) write_fcw(k, W'(32'h100 * (k + 1)), 1'b1);
        repeat (100) tick();
        check_bank("t1_ctrl", '0);
        check_eq("t1_busy", 32'(commit_busy), 32'd0);
        check_eq("t1_ready", 32'(cfg_ready), 32'd1);

        // Normal commit; a write while armed must be rejected.
        commit_arm();
        check_eq("t2_ready_armed", 32'(cfg_ready), 32'd0);
        check_eq("t2_busy_armed", 32'(commit_busy), 32'd1);
        write_fcw(3, 17'h1FFFF, 1'b0);
        check_eq("t2_ready_armed2", 32'(cfg_ready), 32'd0);
        repeat (7) tick();
        check_eq("t2_no_done_yet", 32'(commit_done), 32'd0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        wait_done(4, n);
        check_eq("t2_done_lat", 32'(n), 32'd0);
        check_eq("t2_old_in_apply", 32'(ctrl_fcw[0]), 32'd0);
        check_eq("t2_ready_apply", 32'(cfg_ready), 32'd0);
        apply_check("t2_bank");
        check_eq("t2_ready_idle", 32'(cfg_ready), 32'd1);
        check_eq("t2_busy_idle", 32'(commit_busy), 32'd0);
        check_eq("t2_done_pulse", 32'(commit_done), 32'd0);
`ifdef PRACH_FCW_READBACK_EN
        rd_chn = 3'd5;
        tick();
        check_eq("rd_ch5", 32'(rd_fcw), 32'h600);
`endif

        // commit_req with sync_in from IDLE only arms.
        write_fcw(6, 17'h12345, 1'b1);
        sync_in = 1'b1;
        commit_arm();
        sync_in = 1'b0;
        check_eq("t3_busy", 32'(commit_busy), 32'd1);
        check_eq("t3_done0", 32'(commit_done), 32'd0);
        tick();
        check_eq("t3_done1", 32'(commit_done), 32'd0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check_eq("t3_done", 32'(commit_done), 32'd1);
        apply_check("t3_bank");

        // Timeout forces the copy after TO armed cycles.
        write_fcw(0, 17'h0ABCD, 1'b1);
        commit_arm();
        wait_done(40, n);
        check_eq("t4_to_lat", 32'(n), 32'(TO));
        check_eq("t4_err_set", 32'(err_timeout), 32'd1);
        apply_check("t4_bank");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t4_err_clr", 32'(err_timeout), 32'd0);

        // Clear coincident with a new timeout: the set wins.
        write_fcw(7, 17'h00777, 1'b1);
        commit_arm();
        repeat (TO - 1) tick();
        check_eq("t4b_err_pre", 32'(err_timeout), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t4b_done", 32'(commit_done), 32'd1);
        check_eq("t4b_err_kept", 32'(err_timeout), 32'd1);
        apply_check("t4b_bank");

        // Reset while armed abandons the commit.
        write_fcw(2, 17'h0F0F0, 1'b1);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (3) tick();
        check_eq("t5_busy_armed", 32'(commit_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NCH; k++) shadow_m[k] = '0;
        check_bank("t5_ctrl_rst", '0);
        check_eq("t5_busy_rst", 32'(commit_busy), 32'd0);
        check_eq("t5_err_rst", 32'(err_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (commit_done === 1'b1) seen = 1'b1;
            tick();
        end
        check_eq("t5_no_done", 32'(seen), 32'd0);
        check_eq("t5_busy_after", 32'(commit_busy), 32'd0);
        check_bank("t5_ctrl_after", '0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
